instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/mj32_pkg.sv | 14 +
 rtl/ifq_fifo.sv | 59 +++++
 rtl/instr_prefetch.sv | 129 ++++++++++++
 tb/tb_instr_prefetch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mj32_pkg.sv
// Shared definitions for the mj32 fetch path: prefetch FSM states,
// instruction size and the default reset vector.
package mj32_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } ifq_state_t;

   localparam int          INSTR_BYTES          = 4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/ifq_fifo.sv
// Instruction queue storage: DEPTH entries of {instruction, pc}, with a
// flush that clears the pointers and the count in a single cycle.
module ifq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_pushData,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_headData,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [PW:0]   COUNT_ONE = (PW + 1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [PW:0]      r_count;

   // Pointers wrap naturally because DEPTH is a power of two; flush wins
   // over any push or pop arriving in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wrPtr] <= i_pushData;
            r_wrPtr        <= r_wrPtr + PTR_ONE;
         end
         if (i_pop) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + COUNT_ONE;
            2'b01:   r_count <= r_count - COUNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_headData = r_mem[r_rdPtr];
   assign o_count    = r_count;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: one outstanding imem read at a time, redirect via
// preset, results queued in ifq_fifo. IFETCH_BYPASS_EN adds an empty-queue bypass.
module instr_prefetch
   import mj32_pkg::*;
#(
   parameter int          DEPTH        = 4,
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        preset,
   input  logic [31:0] preset_address,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int            CW         = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   ifq_state_t    r_state;
   ifq_state_t    w_nextState;
   logic [31:0]   r_fetchAddr;
   logic [31:0]   r_imemAddr;
   logic          w_issue;
   logic          w_accept;
   logic          w_bypass;
   logic          w_push;
   logic          w_pop;
   logic          w_queueEmpty;
   logic [CW-1:0] w_count;
   logic [63:0]   w_head;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // w_accept marks the only ack whose data is kept: live request, no redirect.
   always_comb begin
      w_nextState = r_state;
      w_issue     = 1'b0;
      w_accept    = 1'b0;
      imem_req    = 1'b0;
      case (r_state)
         IDLE: begin
            if (!preset && (w_count < FULL_COUNT)) begin
               w_nextState = REQ;
               w_issue     = 1'b1;
            end
         end
         REQ: begin
            imem_req = 1'b1;
            if (preset) begin
               w_nextState = imem_ack ? IDLE : DROP;
            end else if (imem_ack) begin
               w_nextState = IDLE;
               w_accept    = 1'b1;
            end
         end
         DROP: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // A redirect always overrides the sequential increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetchAddr <= RESET_VECTOR;
         r_imemAddr  <= '0;
      end else begin
         if (w_issue) begin
            r_imemAddr <= r_fetchAddr;
         end
         if (preset) begin
            r_fetchAddr <= {preset_address[31:2], 2'b00};
         end else if (w_accept) begin
            r_fetchAddr <= r_fetchAddr + 32'(INSTR_BYTES);
         end
      end
   end

   assign imem_addr    = r_imemAddr;
   assign w_queueEmpty = (w_count == '0);

`ifdef IFETCH_BYPASS_EN
   assign w_bypass    = w_accept && w_queueEmpty;
   assign instr_valid = !w_queueEmpty || w_bypass;
   assign instruction = w_bypass ? imem_rdata : w_head[63:32];
   assign instr_pc    = w_bypass ? r_imemAddr : w_head[31:0];
`else
   assign w_bypass    = 1'b0;
   assign instr_valid = !w_queueEmpty;
   assign instruction = w_head[63:32];
   assign instr_pc    = w_head[31:0];
`endif

   // A bypassed word consumed in the same cycle never enters the queue.
   assign w_push = w_accept && !(w_bypass && instr_ready);
   assign w_pop  = !w_queueEmpty && instr_ready && !preset;

   ifq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_flush    (preset),
      .i_push     (w_push),
      .i_pushData ({imem_rdata, r_imemAddr}),
      .i_pop      (w_pop),
      .o_headData (w_head),
      .o_count    (w_count)
   );

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_instr_prefetch;

   localparam int          DEPTH        = 4;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

   logic        clk            = 1'b0;
   logic        reset          = 1'b1;
   logic        preset         = 1'b0;
   logic [31:0] preset_address = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack       = 1'b0;
   logic [31:0] imem_rdata     = '0;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        instr_ready    = 1'b0;

   int compareCount  = 0;
   int mismatchCount = 0;
   bit bypassMode    = 1'b0;

   // Reference model: expected queue contents plus the outstanding request.
   logic [63:0] mq[$];
   bit          mOut;
   bit          mStale;
   int          mAge;
   int          mDelay;
   int          fixedDelay;
   logic [31:0] mFetch;
   logic [31:0] mReqAddr;

   instr_prefetch #(
      .DEPTH        (DEPTH),
      .RESET_VECTOR (RESET_VECTOR)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .preset         (preset),
      .preset_address (preset_address),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instruction    (instruction),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic bit autoAck();
      return mOut && (mAge >= mDelay);
   endfunction

   function automatic int pickDelay();
      return (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(2, 0));
   endfunction

   // Asserted at a negedge, i.e. asynchronously in the middle of a cycle.
   task automatic doReset();
      reset       = 1'b1;
      preset      = 1'b0;
      imem_ack    = 1'b0;
      instr_ready = 1'b0;
      mq.delete();
      mOut   = 1'b0;
      mStale = 1'b0;
      mAge   = 0;
      mFetch = RESET_VECTOR;
      #1;
      checkOutput("rstReq",   64'(imem_req),    64'(0));
      checkOutput("rstAddr",  64'(imem_addr),   64'(0));
      checkOutput("rstValid", 64'(instr_valid), 64'(0));
      checkOutput("rstInstr", 64'(instruction), 64'(0));
      checkOutput("rstPc",    64'(instr_pc),    64'(0));
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One clock cycle: drive at the negedge, check, advance the model.
   task automatic applyStimulus(input bit p, input logic [31:0] pa, input bit rdy,
                                input bit ack, input logic [31:0] rdata);
      int          sz;
      bit          accept;
      bit          byp;
      bit          expValid;
      logic [63:0] expHead;
      preset         = p;
      preset_address = pa;
      instr_ready    = rdy;
      imem_ack       = ack;
      imem_rdata     = rdata;
      #1;
      sz       = mq.size();
      accept   = mOut && !mStale && ack && !p;
      byp      = bypassMode && accept && (sz == 0);
      expValid = (sz != 0) || byp;
      checkOutput("imemReq", 64'(imem_req), 64'(mOut));
      if (mOut) checkOutput("imemAddr", 64'(imem_addr), 64'(mReqAddr));
      checkOutput("instrValid", 64'(instr_valid), 64'(expValid));
      if (expValid) begin
         expHead = byp ? {rdata, mReqAddr} : mq[0];
         checkOutput("headWord", {instruction, instr_pc}, expHead);
      end
      if (p) begin
         mq.delete();
         mFetch = {pa[31:2], 2'b00};
         if (mOut) begin
            if (ack) mOut = 1'b0;
            else begin
               mStale = 1'b1;
               mAge++;
            end
         end
      end else begin
         if (sz != 0 && rdy) mq.delete(0);
         if (!mOut) begin
            if (sz < DEPTH) begin
               mOut     = 1'b1;
               mStale   = 1'b0;
               mReqAddr = mFetch;
               mAge     = 0;
               mDelay   = pickDelay();
            end
         end else if (ack) begin
            if (!mStale) begin
               if (!(byp && rdy)) mq.push_back({rdata, mReqAddr});
               mFetch = mFetch + 32'd4;
            end
            mOut = 1'b0;
         end else begin
            mAge++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
`ifdef IFETCH_BYPASS_EN
      bypassMode = 1'b1;
`endif
      fixedDelay = 1;
      @(negedge clk);
      doReset();

      // Sequential fetch with ack one cycle into every request.
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, autoAck(), $urandom);

      // Stalled consumer fills the queue, then fetching resumes.
      doReset();
      fixedDelay = 0;
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b0, autoAck(), $urandom);
      checkOutput("fullNoReq", 64'(imem_req), 64'(0));
      for (int i = 0; i < 10 && !imem_req; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, $urandom);
      checkOutput("restartAddr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'(DEPTH * 4)});
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, autoAck(), $urandom);

      // Redirect while the request to 0x8 is outstanding.
      doReset();
      fixedDelay = 1;
      for (int i = 0; i < 20 && !(mOut && mReqAddr == 32'h8); i++)
         applyStimulus(1'b0, '0, 1'b0, autoAck(), $urandom);
      checkOutput("reach8", 64'(mOut && mReqAddr == 32'h8), 64'(1));
      applyStimulus(1'b1, 32'h0000_0101, 1'b0, 1'b0, $urandom);
      for (int i = 0; i < 10 && !(imem_req && imem_addr == 32'h100); i++)
         applyStimulus(1'b0, '0, 1'b1, autoAck(), $urandom);
      checkOutput("redirTarget", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h100});
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, autoAck(), $urandom);

      // Redirect coinciding with an ack and a pop.
      doReset();
      fixedDelay = 0;
      for (int i = 0; i < 20 && !(mOut && !mStale && mq.size() != 0); i++)
         applyStimulus(1'b0, '0, 1'b0, autoAck(), $urandom);
      checkOutput("reach063", 64'(mOut && mq.size() != 0), 64'(1));
      applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b1, $urandom);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, $urandom);
      checkOutput("flushIssue", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h200});

      // Reset during an outstanding request, then a stray ack.
      doReset();
      fixedDelay = 3;
      for (int i = 0; i < 5 && !mOut; i++) applyStimulus(1'b0, '0, 1'b1, autoAck(), $urandom);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, $urandom);
      doReset();
      applyStimulus(1'b0, '0, 1'b1, 1'b1, $urandom);
      checkOutput("postRstAddr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, RESET_VECTOR});
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, autoAck(), $urandom);

      // Ack into an empty queue with the core ready.
      doReset();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, $urandom);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h0000_0013);
      checkOutput("ackNextValid", {31'd0, instr_valid, instruction},
                  bypassMode ? 64'd0 : {31'd0, 1'b1, 32'h0000_0013});

      // Random traffic.
      doReset();
      fixedDelay = -1;
      for (int i = 0; i < 800; i++) begin
         bit p;
         bit ack;
         p   = ($urandom_range(15, 0) == 0);
         ack = autoAck() || (!mOut && $urandom_range(9, 0) == 0);
         applyStimulus(p, $urandom, 1'($urandom_range(1, 0)), ack, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
